// File: rtl/hook_catch_arbiter.sv
// Catch-ownership arbiter: decides which hook holds which collectible object and sequences hold, award and destroy.
// Optional forced-release timeout on a held object is enabled by defining CATCH_TIMEOUT_EN.
module hook_catch_arbiter #(
   parameter int NUM_OBJ       = 8,
   parameter int WEIGHT_W      = 3,
   parameter int VALUE_W       = 8,
   parameter int TICK_DIV      = 8000000,
   parameter int TIMEOUT_TICKS = 40
) (
   input  logic                        Clk,
   input  logic                        reset_n,
   input  logic                        is_new_game_start,
   input  logic [NUM_OBJ-1:0]          hit_l,
   input  logic [NUM_OBJ-1:0]          hit_r,
   input  logic                        hook_home_l,
   input  logic                        hook_home_r,
   input  logic                        is_explodel,
   input  logic                        is_exploder,
   input  logic [NUM_OBJ*WEIGHT_W-1:0] obj_weight,
   input  logic [NUM_OBJ*VALUE_W-1:0]  obj_value,
   output logic [NUM_OBJ-1:0]          grant_l,
   output logic [NUM_OBJ-1:0]          grant_r,
   output logic                        is_catchl,
   output logic                        is_catchr,
   output logic [NUM_OBJ-1:0]          destroy,
   output logic [2:0]                  drag_speed_l,
   output logic [2:0]                  drag_speed_r,
   output logic                        score_pulse_l,
   output logic                        score_pulse_r,
   output logic [VALUE_W-1:0]          score_value_l,
   output logic [VALUE_W-1:0]          score_value_r
);

   typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, AWARD = 2'd2} state_e;

   localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

   function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_OBJ-1:0] v);
      lowest_idx = {IDX_W{1'b0}};
      for (int i = NUM_OBJ - 1; i >= 0; i--) begin
         lowest_idx = v[i] ? IDX_W'(i) : lowest_idx;
      end
   endfunction

   // Heavier objects drag slower; anything at weight 5 or above crawls at 1 px/step.
   function automatic logic [2:0] speed_of(input logic [WEIGHT_W-1:0] w);
      speed_of = (w >= WEIGHT_W'(5)) ? 3'd1 : (3'd6 - 3'(w));
   endfunction

   state_e                 st_l_q, st_l_d, st_r_q, st_r_d;
   logic [NUM_OBJ-1:0]     grant_l_q, grant_l_d, grant_r_q, grant_r_d;
   logic [IDX_W-1:0]       idx_l_q, idx_l_d, idx_r_q, idx_r_d;
   logic [NUM_OBJ-1:0]     destroy_q, destroy_d;
   logic                   rr_last_q, rr_last_d;
   logic                   catch_l_q, catch_l_d, catch_r_q, catch_r_d;
   logic [2:0]             drag_l_q, drag_l_d, drag_r_q, drag_r_d;
   logic                   pulse_l_q, pulse_l_d, pulse_r_q, pulse_r_d;
   logic [VALUE_W-1:0]     val_l_q, val_l_d, val_r_q, val_r_d;

   logic [NUM_OBJ-1:0]     elig_l_s, elig_r_s;
   logic [IDX_W-1:0]       sel_l_s, sel_r_s;
   logic                   contend_s;
   logic                   tmo_l_s, tmo_r_s;
   logic [NUM_OBJ-1:0]     one_s;

   assign one_s     = {{(NUM_OBJ-1){1'b0}}, 1'b1};
   assign elig_l_s  = hit_l & ~destroy_q & ~grant_r_q;
   assign elig_r_s  = hit_r & ~destroy_q & ~grant_l_q;
   assign sel_l_s   = lowest_idx(elig_l_s);
   assign sel_r_s   = lowest_idx(elig_r_s);
   assign contend_s = (st_l_q == IDLE) && (st_r_q == IDLE) && (|elig_l_s) && (|elig_r_s) &&
                      (sel_l_s == sel_r_s);

`ifdef CATCH_TIMEOUT_EN
   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int TCK_W = $clog2(TIMEOUT_TICKS + 1);

   logic [PRE_W-1:0] pre_l_q, pre_l_d, pre_r_q, pre_r_d;
   logic [TCK_W-1:0] tck_l_q, tck_l_d, tck_r_q, tck_r_d;

   // Prescaler and tick counters advance only in HOLD and sit at zero otherwise.
   always_comb begin
      pre_l_d = pre_l_q;
      tck_l_d = tck_l_q;
      pre_r_d = pre_r_q;
      tck_r_d = tck_r_q;
      if ((st_l_q != HOLD) || is_new_game_start) begin
         pre_l_d = '0;
         tck_l_d = '0;
      end else if (pre_l_q == PRE_W'(TICK_DIV - 1)) begin
         pre_l_d = '0;
         tck_l_d = tck_l_q + TCK_W'(1);
      end else begin
         pre_l_d = pre_l_q + PRE_W'(1);
      end
      if ((st_r_q != HOLD) || is_new_game_start) begin
         pre_r_d = '0;
         tck_r_d = '0;
      end else if (pre_r_q == PRE_W'(TICK_DIV - 1)) begin
         pre_r_d = '0;
         tck_r_d = tck_r_q + TCK_W'(1);
      end else begin
         pre_r_d = pre_r_q + PRE_W'(1);
      end
   end

   assign tmo_l_s = (st_l_q == HOLD) && (pre_l_q == PRE_W'(TICK_DIV - 1)) &&
                    (tck_l_q == TCK_W'(TIMEOUT_TICKS - 1));
   assign tmo_r_s = (st_r_q == HOLD) && (pre_r_q == PRE_W'(TICK_DIV - 1)) &&
                    (tck_r_q == TCK_W'(TIMEOUT_TICKS - 1));

   // Timeout counter registers.
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_l_q <= '0;
         tck_l_q <= '0;
         pre_r_q <= '0;
         tck_r_q <= '0;
      end else begin
         pre_l_q <= pre_l_d;
         tck_l_q <= tck_l_d;
         pre_r_q <= pre_r_d;
         tck_r_q <= tck_r_d;
      end
   end
`else
   assign tmo_l_s = 1'b0;
   assign tmo_r_s = 1'b0;
`endif

   // Next-state and registered-output logic for both hook FSMs.
   always_comb begin
      st_l_d    = st_l_q;
      st_r_d    = st_r_q;
      grant_l_d = grant_l_q;
      grant_r_d = grant_r_q;
      idx_l_d   = idx_l_q;
      idx_r_d   = idx_r_q;
      destroy_d = destroy_q;
      pulse_l_d = 1'b0;
      pulse_r_d = 1'b0;
      val_l_d   = {VALUE_W{1'b0}};
      val_r_d   = {VALUE_W{1'b0}};

      // Under contention the hook that did not win last time takes the object.
      if (contend_s) begin
         rr_last_d = ~rr_last_q;
      end else begin
         rr_last_d = rr_last_q;
      end

      case (st_l_q)
         IDLE: begin
            if ((|elig_l_s) && !(contend_s && !rr_last_q)) begin
               st_l_d    = HOLD;
               grant_l_d = one_s << sel_l_s;
               idx_l_d   = sel_l_s;
            end else begin
               st_l_d = IDLE;
            end
         end
         HOLD: begin
            if (is_explodel) begin
               destroy_d[idx_l_q] = 1'b1;
               grant_l_d          = {NUM_OBJ{1'b0}};
               st_l_d             = IDLE;
            end else if (hook_home_l) begin
               st_l_d    = AWARD;
               pulse_l_d = 1'b1;
               val_l_d   = obj_value[idx_l_q*VALUE_W +: VALUE_W];
            end else if (tmo_l_s) begin
               grant_l_d = {NUM_OBJ{1'b0}};
               st_l_d    = IDLE;
            end else begin
               st_l_d = HOLD;
            end
         end
         AWARD: begin
            destroy_d[idx_l_q] = 1'b1;
            grant_l_d          = {NUM_OBJ{1'b0}};
            st_l_d             = IDLE;
         end
         default: begin
            grant_l_d = {NUM_OBJ{1'b0}};
            st_l_d    = IDLE;
         end
      endcase

      case (st_r_q)
         IDLE: begin
            if ((|elig_r_s) && !(contend_s && rr_last_q)) begin
               st_r_d    = HOLD;
               grant_r_d = one_s << sel_r_s;
               idx_r_d   = sel_r_s;
            end else begin
               st_r_d = IDLE;
            end
         end
         HOLD: begin
            if (is_exploder) begin
               destroy_d[idx_r_q] = 1'b1;
               grant_r_d          = {NUM_OBJ{1'b0}};
               st_r_d             = IDLE;
            end else if (hook_home_r) begin
               st_r_d    = AWARD;
               pulse_r_d = 1'b1;
               val_r_d   = obj_value[idx_r_q*VALUE_W +: VALUE_W];
            end else if (tmo_r_s) begin
               grant_r_d = {NUM_OBJ{1'b0}};
               st_r_d    = IDLE;
            end else begin
               st_r_d = HOLD;
            end
         end
         AWARD: begin
            destroy_d[idx_r_q] = 1'b1;
            grant_r_d          = {NUM_OBJ{1'b0}};
            st_r_d             = IDLE;
         end
         default: begin
            grant_r_d = {NUM_OBJ{1'b0}};
            st_r_d    = IDLE;
         end
      endcase

      if (is_new_game_start) begin
         st_l_d    = IDLE;
         st_r_d    = IDLE;
         grant_l_d = {NUM_OBJ{1'b0}};
         grant_r_d = {NUM_OBJ{1'b0}};
         idx_l_d   = {IDX_W{1'b0}};
         idx_r_d   = {IDX_W{1'b0}};
         destroy_d = {NUM_OBJ{1'b0}};
         rr_last_d = 1'b1;
         pulse_l_d = 1'b0;
         pulse_r_d = 1'b0;
         val_l_d   = {VALUE_W{1'b0}};
         val_r_d   = {VALUE_W{1'b0}};
      end else begin
         rr_last_d = rr_last_d;
      end

      catch_l_d = |grant_l_d;
      catch_r_d = |grant_r_d;
      drag_l_d  = (st_l_d == HOLD) ? speed_of(obj_weight[idx_l_d*WEIGHT_W +: WEIGHT_W]) : 3'd6;
      drag_r_d  = (st_r_d == HOLD) ? speed_of(obj_weight[idx_r_d*WEIGHT_W +: WEIGHT_W]) : 3'd6;
   end

   // State and output registers.
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         st_l_q    <= IDLE;
         st_r_q    <= IDLE;
         grant_l_q <= {NUM_OBJ{1'b0}};
         grant_r_q <= {NUM_OBJ{1'b0}};
         idx_l_q   <= {IDX_W{1'b0}};
         idx_r_q   <= {IDX_W{1'b0}};
         destroy_q <= {NUM_OBJ{1'b0}};
         rr_last_q <= 1'b1;
         catch_l_q <= 1'b0;
         catch_r_q <= 1'b0;
         drag_l_q  <= 3'd6;
         drag_r_q  <= 3'd6;
         pulse_l_q <= 1'b0;
         pulse_r_q <= 1'b0;
         val_l_q   <= {VALUE_W{1'b0}};
         val_r_q   <= {VALUE_W{1'b0}};
      end else begin
         st_l_q    <= st_l_d;
         st_r_q    <= st_r_d;
         grant_l_q <= grant_l_d;
         grant_r_q <= grant_r_d;
         idx_l_q   <= idx_l_d;
         idx_r_q   <= idx_r_d;
         destroy_q <= destroy_d;
         rr_last_q <= rr_last_d;
         catch_l_q <= catch_l_d;
         catch_r_q <= catch_r_d;
         drag_l_q  <= drag_l_d;
         drag_r_q  <= drag_r_d;
         pulse_l_q <= pulse_l_d;
         pulse_r_q <= pulse_r_d;
         val_l_q   <= val_l_d;
         val_r_q   <= val_r_d;
      end
   end

   assign grant_l       = grant_l_q;
   assign grant_r       = grant_r_q;
   assign is_catchl     = catch_l_q;
   assign is_catchr     = catch_r_q;
   assign destroy       = destroy_q;
   assign drag_speed_l  = drag_l_q;
   assign drag_speed_r  = drag_r_q;
   assign score_pulse_l = pulse_l_q;
   assign score_pulse_r = pulse_r_q;
   assign score_value_l = val_l_q;
   assign score_value_r = val_r_q;

endmodule

// File: tb/tb_hook_catch_arbiter.sv
// Self-checking bench for hook_catch_arbiter: directed vector table, corner sequences, and random traffic
// compared against an ownership-level reference model (timeout behaviour modelled when CATCH_TIMEOUT_EN is set).
module tb_hook_catch_arbiter;

   localparam int N  = 8;
   localparam int TD = 4;
   localparam int TT = 3;

   logic          Clk = 1'b0;
   logic          reset_n;
   logic          is_new_game_start;
   logic [N-1:0]  hit_l, hit_r;
   logic          hook_home_l, hook_home_r, is_explodel, is_exploder;
   logic [N*3-1:0] obj_weight;
   logic [N*8-1:0] obj_value;
   logic [N-1:0]  grant_l, grant_r, destroy;
   logic          is_catchl, is_catchr, score_pulse_l, score_pulse_r;
   logic [2:0]    drag_speed_l, drag_speed_r;
   logic [7:0]    score_value_l, score_value_r;

   int n_chk  = 0;
   int n_fail = 0;

   hook_catch_arbiter #(.NUM_OBJ(N), .WEIGHT_W(3), .VALUE_W(8), .TICK_DIV(TD), .TIMEOUT_TICKS(TT)) dut (
      .Clk(Clk), .reset_n(reset_n), .is_new_game_start(is_new_game_start),
      .hit_l(hit_l), .hit_r(hit_r), .hook_home_l(hook_home_l), .hook_home_r(hook_home_r),
      .is_explodel(is_explodel), .is_exploder(is_exploder),
      .obj_weight(obj_weight), .obj_value(obj_value),
      .grant_l(grant_l), .grant_r(grant_r), .is_catchl(is_catchl), .is_catchr(is_catchr),
      .destroy(destroy), .drag_speed_l(drag_speed_l), .drag_speed_r(drag_speed_r),
      .score_pulse_l(score_pulse_l), .score_pulse_r(score_pulse_r),
      .score_value_l(score_value_l), .score_value_r(score_value_r)
   );

   always #5 Clk = ~Clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: who owns what ----------------
   int          m_held[2];
   bit          m_awd[2];
   int          m_cnt[2];
   logic [7:0]  m_destroy;
   bit          m_rr_right;
   bit          m_pulse[2];
   logic [7:0]  m_val[2];
   logic [2:0]  m_drag[2];

   function automatic int lowest(input logic [7:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic logic [7:0] onehot(input int i);
      logic [7:0] one = 8'd1;
      return (i < 0) ? 8'd0 : (one << i);
   endfunction

   function automatic logic [2:0] speed(input int w);
      return (w >= 5) ? 3'd1 : 3'(6 - w);
   endfunction

   task automatic model_reset();
      for (int h = 0; h < 2; h++) begin
         m_held[h] = -1; m_awd[h] = 0; m_cnt[h] = 0;
         m_pulse[h] = 0; m_val[h] = 8'd0; m_drag[h] = 3'd6;
      end
      m_destroy  = 8'd0;
      m_rr_right = 1;
   endtask

   task automatic model_step();
      int h_old[2];
      bit a_old[2];
      logic [7:0] d_old, elig;
      int cand[2];
      logic [7:0] hit[2];
      bit home[2], ex[2];
      if (!reset_n || is_new_game_start) begin
         model_reset();
         return;
      end
      hit[0] = hit_l; hit[1] = hit_r;
      home[0] = hook_home_l; home[1] = hook_home_r;
      ex[0] = is_explodel; ex[1] = is_exploder;
      d_old = m_destroy;
      for (int h = 0; h < 2; h++) begin
         h_old[h] = m_held[h]; a_old[h] = m_awd[h];
         m_pulse[h] = 0; m_val[h] = 8'd0;
      end
      for (int h = 0; h < 2; h++) begin
         cand[h] = -1;
         if (h_old[h] < 0) begin
            elig = hit[h] & ~d_old;
            if (h_old[1-h] >= 0) elig[h_old[1-h]] = 1'b0;
            cand[h] = lowest(elig);
         end
      end
      if (cand[0] >= 0 && cand[0] == cand[1]) begin
         if (m_rr_right) cand[1] = -1;
         else cand[0] = -1;
         m_rr_right = !m_rr_right;
      end
      for (int h = 0; h < 2; h++) begin
         if (a_old[h]) begin
            m_destroy[h_old[h]] = 1'b1; m_held[h] = -1; m_awd[h] = 0;
         end else if (h_old[h] >= 0) begin
            if (ex[h]) begin
               m_destroy[h_old[h]] = 1'b1; m_held[h] = -1;
            end else if (home[h]) begin
               m_awd[h] = 1; m_pulse[h] = 1; m_val[h] = obj_value[h_old[h]*8 +: 8];
            end else begin
               m_cnt[h]++;
`ifdef CATCH_TIMEOUT_EN
               if (m_cnt[h] == TD*TT) m_held[h] = -1;
`endif
            end
         end else if (cand[h] >= 0) begin
            m_held[h] = cand[h]; m_cnt[h] = 0;
         end
         m_drag[h] = (m_held[h] >= 0 && !m_awd[h]) ? speed(int'(obj_weight[m_held[h]*3 +: 3])) : 3'd6;
      end
   endtask

   task automatic check_model();
      chk("grant_l", grant_l, onehot(m_held[0]));
      chk("grant_r", grant_r, onehot(m_held[1]));
      chk("is_catchl", is_catchl, (m_held[0] >= 0));
      chk("is_catchr", is_catchr, (m_held[1] >= 0));
      chk("destroy", destroy, m_destroy);
      chk("drag_l", drag_speed_l, m_drag[0]);
      chk("drag_r", drag_speed_r, m_drag[1]);
      chk("pulse_l", score_pulse_l, m_pulse[0]);
      chk("pulse_r", score_pulse_r, m_pulse[1]);
      chk("value_l", score_value_l, m_val[0]);
      chk("value_r", score_value_r, m_val[1]);
   endtask

   task automatic tick();
      @(posedge Clk);
      model_step();
      @(negedge Clk);
   endtask

   task automatic clear_inputs();
      hit_l = 8'd0; hit_r = 8'd0; hook_home_l = 1'b0; hook_home_r = 1'b0;
      is_explodel = 1'b0; is_exploder = 1'b0; is_new_game_start = 1'b0;
   endtask

   typedef struct {
      logic [7:0] hl, hr;
      logic       hml, exl, exr, ngs;
      logic [7:0] gl, gr, dst;
      logic [2:0] dl, dr;
      logic       pl;
      logic [7:0] vl;
   } vec_t;

   vec_t vt[17];
   int   tcnt;

   initial begin
      // weight[i] = i, value[i] = 10*i + 20
      for (int i = 0; i < N; i++) begin
         obj_weight[i*3 +: 3] = 3'(i);
         obj_value[i*8 +: 8]  = 8'(10*i + 20);
      end
      //          hl     hr    hml   exl   exr   ngs   gl     gr     dst    dl    dr    pl    vl
      vt[0]  = '{8'h04, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h04, 8'h00, 8'h00, 3'd4, 3'd6, 1'b0, 8'd0};
      vt[1]  = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h04, 8'h00, 8'h00, 3'd4, 3'd6, 1'b0, 8'd0};
      vt[2]  = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h04, 3'd6, 3'd6, 1'b0, 8'd0};
      vt[3]  = '{8'h10, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 8'h04, 3'd2, 3'd6, 1'b0, 8'd0};
      vt[4]  = '{8'h10, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 8'h04, 3'd2, 3'd6, 1'b0, 8'd0};
      vt[5]  = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h14, 3'd6, 3'd6, 1'b0, 8'd0};
      vt[6]  = '{8'h40, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h40, 8'h14, 3'd6, 3'd1, 1'b0, 8'd0};
      vt[7]  = '{8'h40, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h40, 8'h14, 3'd6, 3'd1, 1'b0, 8'd0};
      vt[8]  = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h54, 3'd6, 3'd6, 1'b0, 8'd0};
      vt[9]  = '{8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h08, 8'h00, 8'h54, 3'd3, 3'd6, 1'b0, 8'd0};
      vt[10] = '{8'h08, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h08, 8'h00, 8'h54, 3'd6, 3'd6, 1'b1, 8'd50};
      vt[11] = '{8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h5C, 3'd6, 3'd6, 1'b0, 8'd0};
      vt[12] = '{8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h5C, 3'd6, 3'd6, 1'b0, 8'd0};
      vt[13] = '{8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 8'h00, 8'h5C, 3'd5, 3'd6, 1'b0, 8'd0};
      vt[14] = '{8'h02, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h5E, 3'd6, 3'd6, 1'b0, 8'd0};
      vt[15] = '{8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h5E, 3'd6, 3'd6, 1'b0, 8'd0};
      vt[16] = '{8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 3'd6, 3'd6, 1'b0, 8'd0};

      reset_n = 1'b0;
      clear_inputs();
      model_reset();
      repeat (2) @(negedge Clk);
      chk("reset_grant_l", grant_l, 8'h00);
      chk("reset_destroy", destroy, 8'h00);
      chk("reset_drag_l", drag_speed_l, 3'd6);
      chk("reset_drag_r", drag_speed_r, 3'd6);
      chk("reset_pulse_l", score_pulse_l, 1'b0);
      reset_n = 1'b1;

      // Directed vector table: one clock per record, outputs checked after the edge.
      for (int v = 0; v < 17; v++) begin
         hit_l = vt[v].hl; hit_r = vt[v].hr; hook_home_l = vt[v].hml; hook_home_r = 1'b0;
         is_explodel = vt[v].exl; is_exploder = vt[v].exr; is_new_game_start = vt[v].ngs;
         tick();
         chk($sformatf("v%0d_grant_l", v), grant_l, vt[v].gl);
         chk($sformatf("v%0d_grant_r", v), grant_r, vt[v].gr);
         chk($sformatf("v%0d_destroy", v), destroy, vt[v].dst);
         chk($sformatf("v%0d_drag_l", v), drag_speed_l, vt[v].dl);
         chk($sformatf("v%0d_drag_r", v), drag_speed_r, vt[v].dr);
         chk($sformatf("v%0d_pulse_l", v), score_pulse_l, vt[v].pl);
         chk($sformatf("v%0d_value_l", v), score_value_l, vt[v].vl);
         chk($sformatf("v%0d_catch_l", v), is_catchl, |vt[v].gl);
      end
      clear_inputs();

      // Destroy every object one at a time, then a new game clears them all.
      hit_l = 8'hFF;
      for (int k = 0; k < N; k++) begin
         tick();
         check_model();
         is_explodel = 1'b1;
         tick();
         check_model();
         is_explodel = 1'b0;
      end
      chk("all_destroyed", destroy, 8'hFF);
      hit_l = 8'h00;
      is_new_game_start = 1'b1;
      tick();
      is_new_game_start = 1'b0;
      chk("newgame_destroy", destroy, 8'h00);
      check_model();

      // Asynchronous reset between edges while holding.
      hit_l = 8'h01;
      tick();
      hit_l = 8'h00;
      chk("pre_reset_hold", grant_l, 8'h01);
      @(posedge Clk);
      model_step();
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      chk("async_grant_l", grant_l, 8'h00);
      chk("async_catch_l", is_catchl, 1'b0);
      chk("async_drag_l", drag_speed_l, 3'd6);
      @(negedge Clk);
      reset_n = 1'b1;
      tick();
      check_model();

`ifdef CATCH_TIMEOUT_EN
      // Forced release after TD*TT cycles in HOLD; object stays collectible.
      hit_l = 8'h01;
      tick();
      hit_l = 8'h00;
      chk("tmo_entry", grant_l, 8'h01);
      tcnt = 0;
      while (grant_l != 8'h00 && tcnt < 40) begin
         tick();
         check_model();
         tcnt++;
      end
      chk("tmo_cycles", 32'(tcnt), 32'(TD*TT));
      chk("tmo_destroy0", destroy[0], 1'b0);
      hit_l = 8'h01;
      tick();
      hit_l = 8'h00;
      chk("tmo_regrant", grant_l, 8'h01);
      is_explodel = 1'b1;
      tick();
      is_explodel = 1'b0;
      check_model();
`endif

      // Random traffic against the reference model.
      for (int c = 0; c < 3000; c++) begin
         if (c % 50 == 0) begin
            obj_weight = 24'($urandom);
            obj_value  = {$urandom, $urandom};
         end
         hit_l = 8'($urandom & $urandom);
         hit_r = ($urandom_range(0, 3) == 0) ? hit_l : 8'($urandom & $urandom);
         hook_home_l = ($urandom_range(0, 5) == 0);
         hook_home_r = ($urandom_range(0, 5) == 0);
         is_explodel = ($urandom_range(0, 11) == 0);
         is_exploder = ($urandom_range(0, 11) == 0);
         is_new_game_start = ($urandom_range(0, 149) == 0);
         tick();
         check_model();
      end
      clear_inputs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/hook_catch_arbiter.md
Name: hook_catch_arbiter

Overview:
- Owns catch ownership of all collectible objects (gold, big stone, diamond) between the left and right hooks.
- Object modules report raw hook-tail overlaps. This block decides which hook holds which object and sequences the hold, award and destroy steps.
- Drives the per-object destroy and catch flags, hook drag speed and score pulses.
- Sits between the object instances and the hook/score controllers.

Parameters:
- NUM_OBJ, 8, number of object slots arbitrated.
- WEIGHT_W, 3, width of each object weight code.
- VALUE_W, 8, width of each object score value.
- TICK_DIV, 8000000, Clk cycles per timeout tick (used only with the optional feature).
- TIMEOUT_TICKS, 40, ticks a hold may last before forced release (used only with the optional feature).

Ports:
- Clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- is_new_game_start  in  1  synchronous clear of all ownership and destroy state.
- hit_l  in  NUM_OBJ  per-object overlap with the left hook tail; bit i means object i is touched.
- hit_r  in  NUM_OBJ  per-object overlap with the right hook tail.
- hook_home_l  in  1  left hook fully retracted.
- hook_home_r  in  1  right hook fully retracted.
- is_explodel  in  1  left player detonates the held object.
- is_exploder  in  1  right player detonates the held object.
- obj_weight  in  NUM_OBJ*WEIGHT_W  packed weights; slot i occupies bits [i*WEIGHT_W +: WEIGHT_W].
- obj_value  in  NUM_OBJ*VALUE_W  packed score values.
- grant_l  out  NUM_OBJ  one-hot object held by the left hook; all zero when none.
- grant_r  out  NUM_OBJ  one-hot object held by the right hook.
- is_catchl  out  1  left hook holding an object.
- is_catchr  out  1  right hook holding an object.
- destroy  out  NUM_OBJ  sticky per-object removed flag.
- drag_speed_l  out  3  left retract speed, px per hook step.
- drag_speed_r  out  3  right retract speed, px per hook step.
- score_pulse_l  out  1  one-cycle award strobe, left.
- score_pulse_r  out  1  one-cycle award strobe, right.
- score_value_l  out  VALUE_W  award amount; valid only while score_pulse_l is high, else 0.
- score_value_r  out  VALUE_W  award amount; valid only while score_pulse_r is high, else 0.

Behaviour:
- Reset (reset_n=0, async):
  - all outputs 0, except drag_speed_l and drag_speed_r = 6;
  - both FSMs in IDLE;
  - rr_last = 1 (right won last), so left has first priority.
- is_new_game_start (sync, highest priority after reset): same values as reset; overrides every other event in that cycle.
- Per-hook FSM, one for each of L and R, states IDLE, HOLD, AWARD, evaluated every Clk.
- Eligible object for a hook: hit bit = 1, destroy bit = 0, and not granted to the other hook.
- IDLE -> HOLD:
  - triggered when any object is eligible;
  - selects the lowest eligible index;
  - grant and is_catch are registered and assert on the next cycle (1-cycle latency).
- Contention:
  - both hooks select the same index in the same cycle: the winner is the hook not equal to rr_last, then rr_last <= winner;
  - the loser stays in IDLE that cycle and re-evaluates next cycle, when the contested object is no longer eligible for it.
- HOLD:
  - grant held constant;
  - drag_speed = 6 - weight, clamped to a minimum of 1 (weight 0 gives 6, weight 5 or more gives 1);
  - ignores hit inputs.
- HOLD + explode for that hook:
  - destroy[i] <= 1, grant cleared, next state IDLE;
  - no score pulse.
- HOLD + hook_home (no explode): -> AWARD.
- HOLD with explode and hook_home in the same cycle: explode wins, no score.
- AWARD (exactly 1 cycle):
  - score_pulse = 1 and score_value = obj_value[i];
  - destroy[i] <= 1, grant cleared;
  - -> IDLE.
- drag_speed returns to 6 in IDLE and AWARD.
- The two FSMs are independent. Both may award in the same cycle (different objects).
- destroy bits are never cleared except by reset or is_new_game_start.
- A destroyed object is never granted again, even if hit stays high.
- hit bits may glitch. Only the registered state matters, with no debouncing.

Optional Feature:
- Macro: CATCH_TIMEOUT_EN.
- Defined:
  - a TICK_DIV prescaler plus a per-hook tick counter run only in HOLD, cleared on entering HOLD;
  - when the counter reaches TIMEOUT_TICKS, the hook force-releases: grant cleared, destroy unchanged (object returns to the free pool), no score, -> IDLE.
- Not defined: no prescaler or counters are synthesized, and HOLD lasts until explode or hook_home.

Test Plan:
- Reset release, then hit_l=8'b0000_0100, weight[2]=2 -> next cycle grant_l=8'b0000_0100, is_catchl=1, drag_speed_l=4.
- hit_l=hit_r=8'b0001_0000 in the same cycle after reset -> grant_l=8'b0001_0000, grant_r=0, right stays IDLE. Repeat on a fresh object 6 -> right wins.
- Left HOLD on obj 3, value[3]=50, hook_home_l=1 -> score_pulse_l=1 for 1 cycle with score_value_l=50, destroy[3]=1; holding hit_l[3]=1 afterwards gives no re-grant.
- Left HOLD on obj 1, is_explodel=1 and hook_home_l=1 in the same cycle -> destroy[1]=1, score_pulse_l stays 0.
- reset_n pulsed low mid-HOLD, asynchronously between edges -> all outputs clear immediately. is_new_game_start with destroy=8'hFF -> destroy=0 next cycle.
- With CATCH_TIMEOUT_EN, TICK_DIV=4, TIMEOUT_TICKS=3, left HOLD on obj 0 with no hook_home -> grant_l clears 12 cycles after HOLD entry, destroy[0]=0, and obj 0 can be granted again.
